// File: rtl/eth_mdio_pkg.sv
// Shared MDIO definitions used by the PHY responder and the station controller.
// Contents: opcode constants, Clause-22 field lengths and the frame state encoding.
package eth_mdio_pkg;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] TA_WR = 2'b10;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned TA_W         = 2;
  localparam int unsigned PREAMBLE_LEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_OP,
    ST_PHY,
    ST_REG,
    ST_TA,
    ST_DATA
  } mdio_state_e;

endpackage

// File: rtl/eth_mdio_sync_edge.sv
// MDC/MDIO input synchronizer with registered MDC rise/fall pulses.
// Ports:
//   Clk, Rst    system clock, synchronous active-high reset
//   mdc_i       raw MDC from the controller (asynchronous)
//   mdio_i      raw MDIO pin value (asynchronous)
//   mdc_rise_o  one-Clk pulse per MDC rising edge
//   mdc_fall_o  one-Clk pulse per MDC falling edge
//   mdio_smp_o  MDIO taken from the same sync stage as MDC, aligned with the pulses
module eth_mdio_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdc_fall_o,
  output logic mdio_smp_o
);

  logic [SYNC_STAGES-1:0] mdc_sync_q;
  logic [SYNC_STAGES-1:0] mdio_sync_q;
  logic                   mdc_prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   smp_q;

  // Both signals share stage depth so the sample tap lines up with the MDC edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      smp_q       <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
      rise_q      <= mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
      fall_q      <= ~mdc_sync_q[SYNC_STAGES-1] & mdc_prev_q;
      smp_q       <= mdio_sync_q[SYNC_STAGES-1];
    end
  end

  assign mdc_rise_o = rise_q;
  assign mdc_fall_o = fall_q;
  assign mdio_smp_o = smp_q;

endmodule

// File: rtl/eth_mdio_phy_resp.sv
// Clause-22 MDIO PHY-side responder: decodes frames from MDC/MDIO, answers reads
// from the register-file port and posts writes as a single-Clk strobe.
// Ports:
//   Clk, Rst              system clock, synchronous active-high reset
//   MDC, MDIO             management clock in, bidirectional data (released unless answering)
//   MDIO_Reg_Rd_Addr/Dat  read lookup address out, data in (valid 1 Clk later)
//   MDIO_Reg_Wr_En/Addr/Dat  write strobe with address and data
//   MDIO_Frame_Err        pulse on malformed/aborted frame addressed to PHY_ADDR
//   MDIO_Busy             high from SOF accept until frame end or abort
module eth_mdio_phy_resp
  import eth_mdio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR     = 5'h01,
  parameter int unsigned       PREAMBLE_MIN = 32,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       TIMEOUT_CLKS = 4096
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MDC,
  inout  wire               MDIO,
  output logic [ADDR_W-1:0] MDIO_Reg_Rd_Addr,
  input  logic [DATA_W-1:0] MDIO_Reg_Rd_Dat,
  output logic              MDIO_Reg_Wr_En,
  output logic [ADDR_W-1:0] MDIO_Reg_Wr_Addr,
  output logic [DATA_W-1:0] MDIO_Reg_Wr_Dat,
  output logic              MDIO_Frame_Err,
  output logic              MDIO_Busy
);

  localparam int unsigned PRE_W = $clog2(PREAMBLE_MIN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

  logic mdc_rise, mdc_fall, smp;

  eth_mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk        (Clk),
    .Rst        (Rst),
    .mdc_i      (MDC),
    .mdio_i     (MDIO),
    .mdc_rise_o (mdc_rise),
    .mdc_fall_o (mdc_fall),
    .mdio_smp_o (smp)
  );

  mdio_state_e       state_q;
  logic [PRE_W-1:0]  pre_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic              op_first_q;
  logic [1:0]        op_q;
  logic [3:0]        phy_sh_q;
  logic [3:0]        reg_sh_q;
  logic              ta_first_q;
  logic [14:0]       wdat_sh_q;
  logic [DATA_W-1:0] rdat_q;
  logic [4:0]        drv_cnt_q;
  logic              rd_act_q;
  logic              addr_ok_q;
  logic              drop_q;
  logic              oe_q;
  logic              out_q;
  logic              busy_q;
  logic              wr_en_q;
  logic              err_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_dat_q;

  // Frame walker: field decode on rise pulses, read drive on fall pulses, timeout abort last.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_first_q <= 1'b0;
      op_q       <= '0;
      phy_sh_q   <= '0;
      reg_sh_q   <= '0;
      ta_first_q <= 1'b0;
      wdat_sh_q  <= '0;
      rdat_q     <= '0;
      drv_cnt_q  <= '0;
      rd_act_q   <= 1'b0;
      addr_ok_q  <= 1'b0;
      drop_q     <= 1'b0;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == ST_IDLE || mdc_rise) tmo_cnt_q <= '0;
      else                                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      if (mdc_rise) begin
        case (state_q)
          ST_IDLE: begin
            if (smp) begin
              if (pre_cnt_q < PRE_W'(PREAMBLE_MIN)) pre_cnt_q <= pre_cnt_q + PRE_W'(1);
            end else if (pre_cnt_q >= PRE_W'(PREAMBLE_MIN)) begin
              state_q   <= ST_SOF;
              busy_q    <= 1'b1;
              addr_ok_q <= 1'b0;
              drop_q    <= 1'b0;
            end else begin
              pre_cnt_q <= '0;
            end
          end
          ST_SOF: begin
            bit_cnt_q <= '0;
            if (smp) begin
              state_q <= ST_OP;
            end else begin
              state_q   <= ST_IDLE;
              pre_cnt_q <= '0;
              busy_q    <= 1'b0;
            end
          end
          ST_OP: begin
            if (bit_cnt_q == 4'd0) begin
              op_first_q <= smp;
              bit_cnt_q  <= 4'd1;
            end else begin
              op_q      <= {op_first_q, smp};
              bit_cnt_q <= '0;
              if ({op_first_q, smp} == OP_RD || {op_first_q, smp} == OP_WR) begin
                state_q <= ST_PHY;
              end else begin
                state_q   <= ST_IDLE;
                pre_cnt_q <= '0;
                busy_q    <= 1'b0;
              end
            end
          end
          ST_PHY: begin
            if (bit_cnt_q == 4'd4) begin
              // Unaddressed frames are still walked to the end, just never answered.
              addr_ok_q <= ({phy_sh_q, smp} == PHY_ADDR);
              drop_q    <= ({phy_sh_q, smp} != PHY_ADDR);
              bit_cnt_q <= '0;
              state_q   <= ST_REG;
            end else begin
              phy_sh_q  <= {phy_sh_q[2:0], smp};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          ST_REG: begin
            if (bit_cnt_q == 4'd4) begin
              rd_addr_q <= {reg_sh_q, smp};
              bit_cnt_q <= '0;
              state_q   <= ST_TA;
            end else begin
              reg_sh_q  <= {reg_sh_q[2:0], smp};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          ST_TA: begin
            if (bit_cnt_q == 4'd0) begin
              ta_first_q <= smp;
              bit_cnt_q  <= 4'd1;
              if (op_q == OP_RD && !drop_q) rdat_q <= MDIO_Reg_Rd_Dat;
            end else begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
              if (op_q == OP_WR && {ta_first_q, smp} != TA_WR) begin
                drop_q <= 1'b1;
                err_q  <= addr_ok_q;
              end
            end
          end
          ST_DATA: begin
            wdat_sh_q <= {wdat_sh_q[13:0], smp};
            if (bit_cnt_q == 4'd15) begin
              state_q   <= ST_IDLE;
              pre_cnt_q <= '0;
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              addr_ok_q <= 1'b0;
              if (op_q == OP_WR && !drop_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= rd_addr_q;
                wr_dat_q  <= {wdat_sh_q, smp};
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      // Read drive: TA bit 2 is 0, then 16 data bits, released on the following fall.
      if (mdc_fall) begin
        if (rd_act_q) begin
          if (drv_cnt_q == 5'd16) begin
            oe_q     <= 1'b0;
            rd_act_q <= 1'b0;
          end else begin
            oe_q      <= 1'b1;
            out_q     <= rdat_q[DATA_W-1];
            rdat_q    <= {rdat_q[DATA_W-2:0], 1'b0};
            drv_cnt_q <= drv_cnt_q + 5'd1;
          end
        end else if (state_q == ST_TA && bit_cnt_q == 4'd1 && op_q == OP_RD && !drop_q) begin
          oe_q      <= 1'b1;
          out_q     <= 1'b0;
          rd_act_q  <= 1'b1;
          drv_cnt_q <= '0;
        end
      end

      if (state_q != ST_IDLE && !mdc_rise && tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
        state_q   <= ST_IDLE;
        pre_cnt_q <= '0;
        bit_cnt_q <= '0;
        busy_q    <= 1'b0;
        oe_q      <= 1'b0;
        rd_act_q  <= 1'b0;
        addr_ok_q <= 1'b0;
        err_q     <= addr_ok_q;
      end
    end
  end

  assign MDIO             = oe_q ? out_q : 1'bz;
  assign MDIO_Reg_Rd_Addr = rd_addr_q;
  assign MDIO_Reg_Wr_En   = wr_en_q;
  assign MDIO_Reg_Wr_Addr = wr_addr_q;
  assign MDIO_Reg_Wr_Dat  = wr_dat_q;
  assign MDIO_Frame_Err   = err_q;
  assign MDIO_Busy        = busy_q;

endmodule

// File: doc/eth_mdio_phy_resp.md
Name: eth_mdio_phy_resp

Overview:
- PHY-side MDIO management responder: the target end of the Clause-22 MDIO frames the station-management controller issues.
- Decodes preamble/SOF/opcode/PHY address/register address from sampled MDC/MDIO.
- Answers reads by driving turnaround + 16 data bits; posts writes to a register-file port.
- Used as a loopback PHY model in FPGA self-test builds and as the synthesizable PHY stand-in for the MDIO bench.

Parameters:
- PHY_ADDR, 5'h01, address this responder answers to.
- PREAMBLE_MIN, 32, consecutive 1 bits required before an SOF is accepted.
- SYNC_STAGES, 2, flops in the MDC/MDIO input synchronizer (min 2).
- TIMEOUT_CLKS, 4096, Clk cycles with no MDC edge before a partial frame is aborted.

Ports:
- Clk  in  1  system clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- MDC  in  1  management clock from controller; asynchronous to Clk.
- MDIO  inout  1  bidirectional serial data; released (Z) except when this block drives read TA/data; external pull-up.
- MDIO_Reg_Rd_Addr  out  5  register address for read lookup.
- MDIO_Reg_Rd_Dat  in  16  read data; valid 1 Clk after MDIO_Reg_Rd_Addr changes.
- MDIO_Reg_Wr_En  out  1  single-Clk write strobe.
- MDIO_Reg_Wr_Addr  out  5  write address; valid with strobe.
- MDIO_Reg_Wr_Dat  out  16  write data; valid with strobe.
- MDIO_Frame_Err  out  1  single-Clk pulse on malformed frame addressed to PHY_ADDR.
- MDIO_Busy  out  1  high from SOF accept until frame end/abort.

Behaviour:
- Input path: MDC and MDIO each pass through SYNC_STAGES flops. Edge detect uses one further flop.
- Rise pulse samples MDIO; fall pulse updates the driven bit. MDIO output changes ≤ SYNC_STAGES+2 Clk after MDC falls.
- MDC high and low phases must each be ≥ SYNC_STAGES+2 Clk.
- Reset values: all outputs 0, MDIO released, preamble count 0, state IDLE.
- Rst mid-frame releases MDIO within 1 Clk; no strobe is issued.
- All bit fields are MSB first.
- State machine, advancing on rise pulses only:
  - IDLE: saturating count of consecutive 1s up to PREAMBLE_MIN; a 0 with count < PREAMBLE_MIN clears the count.
  - IDLE -> SOF: a 0 with count ≥ PREAMBLE_MIN; MDIO_Busy set.
  - SOF: expects 1; a 0 -> IDLE with count 0.
  - OP: 2 bits; 10 = read, 01 = write; 00/11 -> IDLE, no error pulse (unaddressed).
  - PHY_ADDR: 5 bits; on mismatch, set a drop flag and keep walking the frame without driving MDIO.
  - REG_ADDR: 5 bits; MDIO_Reg_Rd_Addr updates after the 5th bit.
  - TA: 2 bits.
    - Read, addressed: do not drive on TA bit 1. Latch MDIO_Reg_Rd_Dat on the TA bit-1 rise. Drive 0 from the next fall (TA bit 2).
    - Write: sampled TA must be 1,0; otherwise drop the write and pulse MDIO_Frame_Err (addressed only).
  - DATA: 16 bits.
    - Read: drive bits 15..0 on successive falls; release on the fall after bit 0.
    - Write: shift in 16 samples; after bit 0, pulse MDIO_Reg_Wr_En for 1 Clk unless dropped.
  - DATA -> IDLE, preamble count 0, MDIO_Busy cleared.
- Back-to-back frames require a fresh PREAMBLE_MIN ones.
- Timeout: in any non-IDLE state, TIMEOUT_CLKS Clk without a rise pulse -> release MDIO, IDLE, MDIO_Frame_Err pulse if addressed, no write.
- Broadcast address 0 is not special; it matches only if PHY_ADDR = 0.

Decomposition:
- Shared package eth_mdio_pkg: opcode constants (RD = 2'b10, WR = 2'b01), field lengths (address 5, data 16, TA 2, preamble 32), state encoding. The package is also imported by the controller.
- One sub-module, eth_mdio_sync_edge: parameterized synchronizer plus rise/fall pulse generator, instantiated for MDC, with the MDIO sample tap taken from the same stage.

Test Plan:
- Read, PHY 1, reg 0x02, file returns 0x0141 -> MDIO Z on TA1, 0 on TA2, then 0000_0001_0100_0001; released after last bit; no Wr_En.
- Write, PHY 1, reg 0x00, data 0x1140, TA 10 -> one MDIO_Reg_Wr_En pulse with Addr = 0x00, Dat = 0x1140; MDIO never driven.
- Read to PHY 3 (PHY_ADDR = 1) -> MDIO stays Z for the entire frame; no Frame_Err; MDIO_Busy falls at frame end.
- Preamble of 20 ones then a valid read -> ignored; the same frame with 32 ones -> answered.
- Write with TA = 11 -> MDIO_Frame_Err pulse, no Wr_En; MDC stopped mid-read for TIMEOUT_CLKS -> MDIO released, Frame_Err pulse.
- Rst asserted during read data bit 7 -> MDIO Z next Clk; the next full frame is answered correctly.
